// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID instruction queue: default depth,
// the NOP word driven when the head is empty, and the stored entry layout.
package if_id_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam logic [31:0] NOP_INSTR = 32'd0;

  // One queued fetch result; pc sits in the upper half of the 64-bit word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } entry_t;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_id_storage.sv
// Entry storage for the IF/ID queue: DEPTH x 64-bit array with one
// synchronous write port and one asynchronous read port. No reset: contents
// are only meaningful where the queue's pointers say an entry is live.
module if_id_storage
  import if_id_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clock,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  entry_t                     wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output entry_t                     rd_data
);

  entry_t mem [DEPTH];

  // Write the tail entry on a push.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue between fetch and decode.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// Optional macro IF_ID_BYPASS_EN: when the queue is empty, an incoming
// instruction is presented on out_* in the same cycle; if decode takes it
// that cycle it is never written to storage.
//
// Handshake: a transfer happens on a rising edge where valid=1 and ready=1
// on the same side and flush=0. in_ready depends only on occupancy (never on
// out_ready, so no write-through when full). flush=1 suppresses both transfers
// and empties the queue on that edge; it also forces out_valid low.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_instruction,
  input  logic [31:0]              in_pc,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [31:0]              out_instruction,
  output logic [31:0]              out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count_q;
  entry_t        head_entry;
  entry_t        in_entry;
  logic          nonempty;
  logic          bypass;
  logic          bypass_taken;
  logic          do_push;
  logic          do_pop;

  assign in_entry = '{pc: in_pc, instruction: in_instruction};
  assign nonempty = (count_q != '0);
  assign in_ready = (count_q < CW'(DEPTH));

`ifdef IF_ID_BYPASS_EN
  assign bypass       = ~nonempty & in_valid & ~flush;
  assign bypass_taken = bypass & out_ready;
`else
  assign bypass       = 1'b0;
  assign bypass_taken = 1'b0;
`endif

  assign out_valid = (nonempty | bypass) & ~flush;
  // A bypassed instruction that decode consumes needs no storage slot.
  assign do_push   = in_valid & in_ready & ~flush & ~bypass_taken;
  assign do_pop    = nonempty & out_ready & ~flush;
  assign count     = count_q;

  if_id_storage #(.DEPTH(DEPTH)) u_storage (
    .clock   (clock),
    .wr_en   (do_push),
    .wr_addr (tail),
    .wr_data (in_entry),
    .rd_addr (head),
    .rd_data (head_entry)
  );

  // Pointer and occupancy update; flush empties the queue ahead of any transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop)  head <= head + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head presentation: NOP and zero PC whenever nothing is valid.
  always_comb begin
    out_instruction = NOP_INSTR;
    out_pc          = '0;
    if (out_valid) begin
      if (bypass) begin
        out_instruction = in_instruction;
        out_pc          = in_pc;
      end else begin
        out_instruction = head_entry.instruction;
        out_pc          = head_entry.pc;
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Testbench for if_id_queue: a directed vector table from reset, then
// hand-written sequences checked against a reference queue model.
module tb_if_id_queue;
  import if_id_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IF_ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic [31:0]   in_instruction;
  logic [31:0]   in_pc;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic [31:0]   out_instruction;
  logic [31:0]   out_pc;
  logic          out_ready;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference queue contents, {pc, instruction}, head at index 0.
  logic [63:0] exp_q[$];

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ordy;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [31:0] ec;
    logic        er;
  } vec_t;

  vec_t vecs[12];

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_instruction  (in_instruction),
    .in_pc           (in_pc),
    .in_ready        (in_ready),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_ready       (out_ready),
    .count           (count)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    in_valid       = iv;
    in_instruction = instr;
    in_pc          = pc;
    flush          = fl;
    out_ready      = ordy;
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                              input logic ordy, input logic ev, input logic [31:0] ei,
                              input logic [31:0] ep, input logic [31:0] ec, input logic er);
    vec_t v;
    v.iv = iv; v.instr = instr; v.pc = pc; v.ordy = ordy;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec; v.er = er;
    return v;
  endfunction

  // One cycle against the reference model: drive at the falling edge, check
  // pre-edge outputs, update the model, then advance through the rising edge.
  task automatic step(input string tag, input logic iv, input logic [31:0] instr,
                      input logic [31:0] pc, input logic fl, input logic ordy);
    int          pre;
    bit          byp;
    bit          exp_v;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [63:0] head_e;
    drive(iv, instr, pc, fl, ordy);
    #2;
    pre   = exp_q.size();
    byp   = BYP && (pre == 0) && iv && !fl;
    exp_v = 1'b0;
    ei    = 32'd0;
    ep    = 32'd0;
    if (!fl) begin
      if (pre > 0) begin
        head_e = exp_q[0];
        exp_v  = 1'b1;
        ep     = head_e[63:32];
        ei     = head_e[31:0];
      end else if (byp) begin
        exp_v = 1'b1;
        ei    = instr;
        ep    = pc;
      end
    end
    check({tag, ".out_valid"},       {31'd0, out_valid}, {31'd0, exp_v});
    check({tag, ".out_instruction"}, out_instruction, ei);
    check({tag, ".out_pc"},          out_pc, ep);
    check({tag, ".count"},           {{(32-CW){1'b0}}, count}, pre);
    check({tag, ".in_ready"},        {31'd0, in_ready}, {31'd0, (pre < DEPTH)});
    if (fl) begin
      exp_q.delete();
    end else begin
      if (exp_v && ordy && pre > 0) void'(exp_q.pop_front());
      if (iv && pre < DEPTH && !(byp && ordy)) exp_q.push_back({pc, instr});
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    // Directed table from reset: fill to full, ignored fifth push, drain in order.
    vecs[0]  = mk(1, 32'h0000_0013, 32'h00, 0, BYP, BYP ? 32'h13 : 32'h0, 32'h0, 0, 1);
    vecs[1]  = mk(0, 32'h0,         32'h00, 0, 1, 32'h13, 32'h0, 1, 1);
    vecs[2]  = mk(1, 32'h0000_00A4, 32'h04, 0, 1, 32'h13, 32'h0, 1, 1);
    vecs[3]  = mk(1, 32'h0000_00A8, 32'h08, 0, 1, 32'h13, 32'h0, 2, 1);
    vecs[4]  = mk(1, 32'h0000_00AC, 32'h0C, 0, 1, 32'h13, 32'h0, 3, 1);
    vecs[5]  = mk(1, 32'h0000_00B0, 32'h10, 0, 1, 32'h13, 32'h0, 4, 0);
    vecs[6]  = mk(0, 32'h0,         32'h00, 0, 1, 32'h13, 32'h0, 4, 0);
    vecs[7]  = mk(0, 32'h0,         32'h00, 1, 1, 32'h13, 32'h0, 4, 0);
    vecs[8]  = mk(0, 32'h0,         32'h00, 1, 1, 32'hA4, 32'h4, 3, 1);
    vecs[9]  = mk(0, 32'h0,         32'h00, 1, 1, 32'hA8, 32'h8, 2, 1);
    vecs[10] = mk(0, 32'h0,         32'h00, 1, 1, 32'hAC, 32'hC, 1, 1);
    vecs[11] = mk(0, 32'h0,         32'h00, 1, 0, 32'h0,  32'h0, 0, 1);

    // Reset state
    reset = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0);
    repeat (2) @(negedge clock);
    #2;
    check("reset.out_valid",       {31'd0, out_valid}, 32'd0);
    check("reset.out_instruction", out_instruction, 32'd0);
    check("reset.out_pc",          out_pc, 32'd0);
    check("reset.count",           {{(32-CW){1'b0}}, count}, 32'd0);
    check("reset.in_ready",        {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].iv, vecs[i].instr, vecs[i].pc, 1'b0, vecs[i].ordy);
      #2;
      check($sformatf("vec%0d.out_valid", i),       {31'd0, out_valid}, {31'd0, vecs[i].ev});
      check($sformatf("vec%0d.out_instruction", i), out_instruction, vecs[i].ei);
      check($sformatf("vec%0d.out_pc", i),          out_pc, vecs[i].ep);
      check($sformatf("vec%0d.count", i),           {{(32-CW){1'b0}}, count}, vecs[i].ec);
      check($sformatf("vec%0d.in_ready", i),        {31'd0, in_ready}, {31'd0, vecs[i].er});
      @(posedge clock);
      @(negedge clock);
    end

    // Full queue with simultaneous push and pop: the push must not slip in.
    for (int k = 0; k < 4; k++) step("fill", 1, 32'h1000 + k, 32'h100 + 4 * k, 0, 0);
    step("full_pushpop", 1, 32'h2000, 32'h200, 0, 1);
    for (int k = 0; k < 4; k++) step("full_drain", 0, 32'h0, 32'h0, 0, 1);

    // Steady push+pop at count 2 for 10 cycles: pointers wrap, order holds.
    for (int k = 0; k < 2; k++) step("pp_fill", 1, 32'h3000 + k, 32'h300 + 4 * k, 0, 0);
    for (int k = 2; k < 12; k++) step("pp", 1, 32'h3000 + k, 32'h300 + 4 * k, 0, 1);
    for (int k = 0; k < 3; k++) step("pp_drain", 0, 32'h0, 32'h0, 0, 1);

    // Flush at count 3 with an incoming PC 0x20 and decode ready: all dropped.
    for (int k = 0; k < 3; k++) step("fl_fill", 1, 32'h5000 + k, 32'h500 + 4 * k, 0, 0);
    step("flush", 1, 32'h0000_0020, 32'h20, 1, 1);
    for (int k = 0; k < 2; k++) step("post_flush", 0, 32'h0, 32'h0, 0, 1);

    // Asynchronous reset between edges at count 2.
    for (int k = 0; k < 2; k++) step("rst_fill", 1, 32'h6000 + k, 32'h600 + 4 * k, 0, 0);
    drive(0, 32'h0, 32'h0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst.out_valid",       {31'd0, out_valid}, 32'd0);
    check("async_rst.count",           {{(32-CW){1'b0}}, count}, 32'd0);
    check("async_rst.in_ready",        {31'd0, in_ready}, 32'd1);
    check("async_rst.out_instruction", out_instruction, 32'd0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    step("post_rst_push", 1, 32'h0000_0777, 32'h700, 0, 0);
    step("post_rst_pop", 0, 32'h0, 32'h0, 0, 1);
    step("post_rst_idle", 0, 32'h0, 32'h0, 0, 1);

    // Empty queue push with decode ready (bypass case when enabled).
    step("byp_take", 1, 32'h0000_4000, 32'h40, 0, 1);
    step("byp_after", 0, 32'h0, 32'h0, 0, 1);
    step("byp_idle", 0, 32'h0, 32'h0, 0, 0);
    // Empty queue push with decode stalled: must be stored.
    step("byp_stall", 1, 32'h0000_4400, 32'h44, 0, 0);
    step("byp_stored", 0, 32'h0, 32'h0, 0, 1);
    step("byp_end", 0, 32'h0, 32'h0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, minimum 2.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 in_valid  in  1  fetch stage presents an instruction this cycle.
REQ-005 in_instruction  in  32  fetched instruction word.
REQ-006 in_pc  in  32  PC of the fetched instruction.
REQ-007 in_ready  out  1  queue accepts a push this cycle.
REQ-008 flush  in  1  branch taken; discard all queued and incoming instructions.
REQ-009 out_valid  out  1  head entry available to decode.
REQ-010 out_instruction  out  32  head instruction; 32'd0 (NOP) when out_valid=0.
REQ-011 out_pc  out  32  head PC; 32'd0 when out_valid=0.
REQ-012 out_ready  in  1  decode consumes the head this cycle (not stalled).
REQ-013 count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 Push occurs when in_valid=1, in_ready=1 and flush=0; entry {in_pc, in_instruction} written at tail, tail advances.
REQ-015 Pop occurs when out_valid=1, out_ready=1 and flush=0; head advances.
REQ-016 in_ready SHALL be 1 exactly when count<DEPTH; no write-through when full, even if a pop occurs that cycle.
REQ-017 out_valid SHALL be 1 exactly when count>0 and flush=0.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-019 Head and tail pointers SHALL wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-020 Push attempted when full SHALL be ignored without state change; pop attempted when empty SHALL be ignored.
REQ-021 flush=1 SHALL, on the next edge, set count=0 and pointers equal, discarding the input presented that cycle.
REQ-022 flush has priority over push and pop in the same cycle.
REQ-023 Default latency: an instruction pushed at edge N is visible on out_* after edge N (one cycle).

Reset
REQ-024 While reset=0: count=0, head=tail=0, out_valid=0, out_instruction=0, out_pc=0, in_ready=1.
REQ-025 Reset asserted mid-operation SHALL discard all entries; storage contents need not be cleared.
REQ-026 First push accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro IF_ID_BYPASS_EN: when defined, if count=0, in_valid=1, flush=0, input appears on out_* in the same cycle with out_valid=1; if also out_ready=1 nothing is stored.
REQ-028 With IF_ID_BYPASS_EN defined and bypass not consumed (out_ready=0), the entry is stored as a normal push.
REQ-029 Without IF_ID_BYPASS_EN, out_* depend only on registered state (REQ-023 latency).

Structure
REQ-030 Shared package if_id_pkg SHALL hold: DEPTH default, NOP_INSTR=32'd0, entry struct {pc[31:0], instruction[31:0]}.
REQ-031 Entry storage SHALL be a sub-module if_id_storage (DEPTH x 64-bit, one write port, one async read port); pointer/count control stays in if_id_queue.

Verification
REQ-032 Reset released, push 0x00000013@PC 0x0 with out_ready=0 -> next cycle out_valid=1, out_instruction=0x00000013, out_pc=0x0, count=1.
REQ-033 Push 4 entries (PC 0x0,0x4,0x8,0xC) with out_ready=0 -> count=4, in_ready=0; fifth push ignored; popping yields PCs 0x0,0x4,0x8,0xC in order.
REQ-034 count=2, push and pop same cycle for 10 cycles -> count stays 2, pointers wrap, order preserved.
REQ-035 count=3, flush=1 with in_valid=1 (PC 0x20) -> next cycle count=0, out_valid=0, out_instruction=0; PC 0x20 never emitted.
REQ-036 count=2, assert reset=0 between edges -> out_valid=0 and count=0 immediately, in_ready=1.
REQ-037 IF_ID_BYPASS_EN defined, empty, push PC 0x40 with out_ready=1 -> same cycle out_valid=1, out_pc=0x40; next cycle count=0.
